// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - data memory controller with byte/half/word access and valid/ready handshake
// Define DM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them down.
`timescale 1ns/1ps
module dm_ctrl #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0,
    parameter bit BIG_ENDIAN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_sext,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);
    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state;
    logic [3:0]              waitCnt;
    logic                    latWe;
    logic [1:0]              latSize;
    logic                    latSext;
    logic [ADDR_WIDTH-1:0]   latAddr;
    logic [31:0]             latWdata;

    logic [31:0]             mem [0:DEPTH-1];

    logic [ADDR_WIDTH-3:0]   wordIdx;
    logic [1:0]              offset;
    logic [1:0]              lane;
    logic                    accErr;
    logic                    doAccess;
    logic [31:0]             curWord;
    logic [7:0]              byteVal;
    logic [15:0]             halfVal;
    logic [31:0]             loadData;
    logic [31:0]             storeWord;

    assign wordIdx  = latAddr[ADDR_WIDTH-1:2];
    assign lane     = BIG_ENDIAN ? (offset ^ 2'b11) : offset;
    assign doAccess = (state == ACCESS) && (waitCnt == 4'd0);

`ifdef DM_MISALIGN_TRAP_EN
    assign accErr = (latSize == 2'b11)
                 || (latSize == 2'b01 && latAddr[0])
                 || (latSize == 2'b10 && latAddr[1:0] != 2'b00);
`else
    assign accErr = (latSize == 2'b11);
`endif

    // Halves and words are aligned down; under the trap build the misaligned case never reaches memory.
    always_comb begin
        offset = latAddr[1:0];
        case (latSize)
            2'b01:   offset = {latAddr[1], 1'b0};
            2'b10:   offset = 2'b00;
            default: offset = latAddr[1:0];
        endcase
    end

    always_comb begin
        curWord   = mem[wordIdx];
        byteVal   = curWord[{lane, 3'b000} +: 8];
        halfVal   = curWord[{lane[1], 4'b0000} +: 16];
        loadData  = curWord;
        storeWord = curWord;
        case (latSize)
            2'b00: begin
                loadData = {{24{latSext & byteVal[7]}}, byteVal};
                storeWord[{lane, 3'b000} +: 8] = latWdata[7:0];
            end
            2'b01: begin
                loadData = {{16{latSext & halfVal[15]}}, halfVal};
                storeWord[{lane[1], 4'b0000} +: 16] = latWdata[15:0];
            end
            default: storeWord = latWdata;
        endcase
    end

    // Array is not reset; an asynchronous reset forces state to IDLE so no commit can follow it.
    always_ff @(posedge clk) begin
        if (doAccess && latWe && !accErr)
            mem[wordIdx] <= storeWord;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            waitCnt   <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            latWe     <= 1'b0;
            latSize   <= 2'b00;
            latSext   <= 1'b0;
            latAddr   <= '0;
            latWdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        latWe     <= req_we;
                        latSize   <= req_size;
                        latSext   <= req_sext;
                        latAddr   <= req_addr;
                        latWdata  <= req_wdata;
                        waitCnt   <= 4'(WAIT_STATES);
                        req_ready <= 1'b0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (waitCnt != 4'd0) begin
                        waitCnt <= waitCnt - 4'd1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= accErr;
                        rsp_rdata <= (latWe || accErr) ? 32'd0 : loadData;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_ctrl.sv
// tb/tb_dm_ctrl.sv - directed-vector bench for dm_ctrl
// Instance 0 runs with WAIT_STATES=0, instance 1 with WAIT_STATES=2.
`timescale 1ns/1ps
module tb_dm_ctrl;
    logic             clk;
    logic [1:0]       rstN;
    logic [1:0]       reqValid;
    logic [1:0]       reqReady;
    logic [1:0]       reqWe;
    logic [1:0][1:0]  reqSize;
    logic [1:0]       reqSext;
    logic [1:0][11:0] reqAddr;
    logic [1:0][31:0] reqWdata;
    logic [1:0]       rspValid;
    logic [1:0]       rspReady;
    logic [1:0][31:0] rspRdata;
    logic [1:0]       rspErr;

    int nVec  = 0;
    int nMiss = 0;

    dm_ctrl #(.ADDR_WIDTH(12), .WAIT_STATES(0), .BIG_ENDIAN(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rstN[0]), .req_valid(reqValid[0]), .req_ready(reqReady[0]),
        .req_we(reqWe[0]), .req_size(reqSize[0]), .req_sext(reqSext[0]), .req_addr(reqAddr[0]),
        .req_wdata(reqWdata[0]), .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]),
        .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0])
    );

    dm_ctrl #(.ADDR_WIDTH(12), .WAIT_STATES(2), .BIG_ENDIAN(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rstN[1]), .req_valid(reqValid[1]), .req_ready(reqReady[1]),
        .req_we(reqWe[1]), .req_size(reqSize[1]), .req_sext(reqSext[1]), .req_addr(reqAddr[1]),
        .req_wdata(reqWdata[1]), .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]),
        .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMiss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request with rsp_ready held high; lat counts edges from accept to rsp_valid.
    task automatic doReq(input int d, input logic we, input logic [1:0] size, input logic sext,
                         input logic [11:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        reqValid[d] = 1'b1;
        reqWe[d]    = we;
        reqSize[d]  = size;
        reqSext[d]  = sext;
        reqAddr[d]  = addr;
        reqWdata[d] = wdata;
        rspReady[d] = 1'b1;
        @(posedge clk);
        #1 reqValid[d] = 1'b0;
        lat = 0;
        while (!rspValid[d] && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!rspValid[d]) checkVec("rsp_timeout", 32'd0, 32'd1);
        rdata = rspRdata[d];
        err   = rspErr[d];
        @(posedge clk);
        #1 rspReady[d] = 1'b0;
    endtask

    task automatic loadChk(input int d, input string tag, input logic [1:0] size, input logic sext,
                           input logic [11:0] addr, input logic [31:0] expData, input logic expErr);
        logic [31:0] rd;
        logic        er;
        int          lat;
        doReq(d, 1'b0, size, sext, addr, 32'd0, rd, er, lat);
        checkVec(tag, rd, expData);
        checkVec({tag, "_err"}, {31'd0, er}, {31'd0, expErr});
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] holdData;

        rstN     = 2'b00;
        reqValid = '0;
        reqWe    = '0;
        reqSize  = '0;
        reqSext  = '0;
        reqAddr  = '0;
        reqWdata = '0;
        rspReady = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checkVec("rst_req_ready", {31'd0, reqReady[d]}, 32'd1);
            checkVec("rst_rsp_valid", {31'd0, rspValid[d]}, 32'd0);
            checkVec("rst_rsp_rdata", rspRdata[d], 32'd0);
            checkVec("rst_rsp_err",   {31'd0, rspErr[d]},   32'd0);
        end
        @(negedge clk);
        rstN = 2'b11;

        doReq(0, 1'b1, 2'b10, 1'b0, 12'h010, 32'h12345678, rd, er, lat);
        checkVec("st_word_rdata", rd, 32'd0);
        checkVec("st_word_err", {31'd0, er}, 32'd0);
        checkVec("st_word_lat", lat, 32'd1);
        doReq(0, 1'b0, 2'b10, 1'b0, 12'h010, 32'd0, rd, er, lat);
        checkVec("ld_word", rd, 32'h12345678);
        checkVec("ld_word_lat", lat, 32'd1);
        loadChk(0, "ld_b010",   2'b00, 1'b0, 12'h010, 32'h00000012, 1'b0);
        loadChk(0, "ld_b013",   2'b00, 1'b0, 12'h013, 32'h00000078, 1'b0);
        loadChk(0, "ld_h012",   2'b01, 1'b0, 12'h012, 32'h00005678, 1'b0);
        loadChk(0, "ld_h010_s", 2'b01, 1'b1, 12'h010, 32'h00001234, 1'b0);

        doReq(0, 1'b1, 2'b00, 1'b0, 12'h011, 32'h000000AB, rd, er, lat);
        loadChk(0, "ld_w_after_sb", 2'b10, 1'b0, 12'h010, 32'h12AB5678, 1'b0);
        loadChk(0, "ld_b011_s",     2'b00, 1'b1, 12'h011, 32'hFFFFFFAB, 1'b0);
        loadChk(0, "ld_b011_z",     2'b00, 1'b0, 12'h011, 32'h000000AB, 1'b0);
        loadChk(0, "ld_w_sext_ign", 2'b10, 1'b1, 12'h010, 32'h12AB5678, 1'b0);

`ifdef DM_MISALIGN_TRAP_EN
        loadChk(0, "ld_w012_mis", 2'b10, 1'b0, 12'h012, 32'd0, 1'b1);
        loadChk(0, "ld_h011_mis", 2'b01, 1'b0, 12'h011, 32'd0, 1'b1);
`else
        loadChk(0, "ld_w012_mis", 2'b10, 1'b0, 12'h012, 32'h12AB5678, 1'b0);
        loadChk(0, "ld_h011_mis", 2'b01, 1'b0, 12'h011, 32'h000012AB, 1'b0);
`endif
        loadChk(0, "ld_rsvd", 2'b11, 1'b0, 12'h010, 32'd0, 1'b1);
        doReq(0, 1'b1, 2'b11, 1'b0, 12'h010, 32'hFFFFFFFF, rd, er, lat);
        checkVec("st_rsvd_err", {31'd0, er}, 32'd1);
        loadChk(0, "ld_after_rsvd_st", 2'b10, 1'b0, 12'h010, 32'h12AB5678, 1'b0);

        // Handshake on the wait-state instance.
        doReq(1, 1'b1, 2'b10, 1'b0, 12'h010, 32'hCAFEF00D, rd, er, lat);
        checkVec("ws2_st_lat", lat, 32'd3);
        @(negedge clk);
        reqValid[1] = 1'b1;
        reqWe[1]    = 1'b0;
        reqSize[1]  = 2'b10;
        reqAddr[1]  = 12'h010;
        rspReady[1] = 1'b0;
        @(posedge clk);
        #1 reqWe[1] = 1'b1;
        reqAddr[1]  = 12'h020;
        reqWdata[1] = 32'h55AA55AA;
        lat = 0;
        while (!rspValid[1] && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        checkVec("ws2_ld_lat", lat, 32'd3);
        holdData = rspRdata[1];
        checkVec("ws2_ld_data", holdData, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkVec("hold_valid", {31'd0, rspValid[1]}, 32'd1);
            checkVec("hold_rdata", rspRdata[1], 32'hCAFEF00D);
            checkVec("hold_err",   {31'd0, rspErr[1]},   32'd0);
            checkVec("hold_ready", {31'd0, reqReady[1]}, 32'd0);
        end
        rspReady[1] = 1'b1;
        @(posedge clk);
        #1 rspReady[1] = 1'b0;
        checkVec("taken_valid", {31'd0, rspValid[1]}, 32'd0);
        checkVec("taken_ready", {31'd0, reqReady[1]}, 32'd1);
        @(posedge clk);
        #1 reqValid[1] = 1'b0;
        checkVec("late_accept", {31'd0, reqReady[1]}, 32'd0);
        rspReady[1] = 1'b1;
        lat = 0;
        while (reqReady[1] == 1'b0 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        rspReady[1] = 1'b0;
        loadChk(1, "ld_020", 2'b10, 1'b0, 12'h020, 32'h55AA55AA, 1'b0);
        loadChk(1, "ld_010_keep", 2'b10, 1'b0, 12'h010, 32'hCAFEF00D, 1'b0);

        // Reset while the store is still in its wait states.
        @(negedge clk);
        reqValid[1] = 1'b1;
        reqWe[1]    = 1'b1;
        reqSize[1]  = 2'b10;
        reqAddr[1]  = 12'h010;
        reqWdata[1] = 32'hDEADBEEF;
        rspReady[1] = 1'b1;
        @(posedge clk);
        #1 reqValid[1] = 1'b0;
        #1 rstN[1] = 1'b0;
        #1;
        checkVec("mid_rst_valid", {31'd0, rspValid[1]}, 32'd0);
        checkVec("mid_rst_ready", {31'd0, reqReady[1]}, 32'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkVec("mid_rst_hold_valid", {31'd0, rspValid[1]}, 32'd0);
        rstN[1] = 1'b1;
        rspReady[1] = 1'b0;
        loadChk(1, "ld_after_rst", 2'b10, 1'b0, 12'h010, 32'hCAFEF00D, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
